lfsr_checker: RTL and testbench

Downstream consumer of the 16-bit Fibonacci LFSR generator. It synchronises to the incoming pseudo-random word stream and predicts each next word. It reports lock status, flags every mismatch once locked, and keeps a saturating error count. It sits at the receive end of a PRBS link or BIST path, one word per `in_valid` beat.

---
 rtl/lfsr_checker.sv | 125 ++++++++++++
 tb/tb_lfsr_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - 16-bit Fibonacci LFSR stream checker with lock tracking and error count
module lfsr_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int LW = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // x^16+x^14+x^13+x^11+1, same taps as the generator
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    state_t            state, state_d;
    logic [15:0]       expected, expected_d;
    logic [MW-1:0]     match_cnt, match_cnt_d, match_inc;
    logic [LW-1:0]     miss_cnt, miss_cnt_d, miss_inc;
    logic              pulse_d;
    logic [ERR_W-1:0]  err_count_d;

    assign match_inc = match_cnt + MW'(1);
    assign miss_inc  = miss_cnt + LW'(1);

    // Next-state, prediction and error decision for the current beat
    always_comb begin
        state_d     = state;
        expected_d  = expected;
        match_cnt_d = match_cnt;
        miss_cnt_d  = miss_cnt;
        pulse_d     = 1'b0;
        if (in_valid) begin
            case (state)
                SEARCH: begin
                    // the all-zero lockup word cannot seed the predictor
                    if (in_data != 16'h0000) begin
                        expected_d  = lfsr_next(in_data);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data == expected) begin
                        expected_d  = lfsr_next(in_data);
                        match_cnt_d = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (in_data != 16'h0000) begin
                        expected_d  = lfsr_next(in_data);
                        match_cnt_d = '0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (in_data == expected) begin
                        expected_d = lfsr_next(in_data);
                        miss_cnt_d = '0;
                    end else begin
                        // flywheel on our own prediction so a single bad word costs one error
                        expected_d = lfsr_next(expected);
                        miss_cnt_d = miss_inc;
                        pulse_d    = 1'b1;
                        if (miss_inc == LW'(LOSS_COUNT)) begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Saturating error counter; clear wins over a coincident increment
    always_comb begin
        err_count_d = err_count;
        if (clear) begin
            err_count_d = '0;
        end else if (pulse_d && (err_count != {ERR_W{1'b1}})) begin
            err_count_d = err_count + ERR_W'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= SEARCH;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            expected  <= expected_d;
            match_cnt <= match_cnt_d;
            miss_cnt  <= miss_cnt_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= pulse_d;
            err_count <= err_count_d;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker, default and small-counter instances
module tb_lfsr_checker;

    logic        clk;
    logic        nReset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        clear;

    logic        locked_a, err_pulse_a;
    logic [15:0] err_count_a;
    logic        locked_b, err_pulse_b;
    logic [1:0]  err_count_b;

    lfsr_checker dut_a (
        .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a)
    );

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_W(2)) dut_b (
        .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b)
    );

    typedef struct {
        bit          lk;
        bit          seeded;
        int          prog;
        int          misses;
        bit [15:0]   exp;
        int          errs;
        bit          pulse;
    } mdl_t;

    typedef struct {
        bit a_lk; bit a_p; int a_cnt;
        bit b_lk; bit b_p; int b_cnt;
    } exp_t;

    mdl_t ma, mb;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    function automatic bit [15:0] nxt(input bit [15:0] x);
        int fb;
        fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return 16'(((int'(x) << 1) & 16'hFFFF) | fb);
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.lk = 0; m.seeded = 0; m.prog = 0; m.misses = 0;
        m.exp = 0; m.errs = 0; m.pulse = 0;
        return m;
    endfunction

    // Behaviour of one beat: seeded/unseeded search, progress toward lock, flywheel when locked
    function automatic mdl_t step(input mdl_t m, input bit v, input bit [15:0] d, input bit clr,
                                  input int lock_n, input int loss_n, input int emax);
        m.pulse = 0;
        if (v) begin
            if (m.lk) begin
                if (d == m.exp) begin
                    m.exp = nxt(d);
                    m.misses = 0;
                end else begin
                    m.pulse = 1;
                    m.exp = nxt(m.exp);
                    m.misses++;
                    if (m.misses == loss_n) begin
                        m.lk = 0;
                        m.seeded = 0;
                    end
                end
            end else if (!m.seeded) begin
                if (d != 0) begin
                    m.seeded = 1;
                    m.exp = nxt(d);
                    m.prog = 0;
                end
            end else if (d == m.exp) begin
                m.exp = nxt(d);
                m.prog++;
                if (m.prog == lock_n) begin
                    m.lk = 1;
                    m.misses = 0;
                end
            end else if (d != 0) begin
                m.exp = nxt(d);
                m.prog = 0;
            end else begin
                m.seeded = 0;
            end
        end
        if (clr) m.errs = 0;
        else if (m.pulse && m.errs < emax) m.errs++;
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("a_locked", int'(locked_a), int'(e.a_lk));
        chk("a_err_pulse", int'(err_pulse_a), int'(e.a_p));
        chk("a_err_count", int'(err_count_a), e.a_cnt);
        chk("b_locked", int'(locked_b), int'(e.b_lk));
        chk("b_err_pulse", int'(err_pulse_b), int'(e.b_p));
        chk("b_err_count", int'(err_count_b), e.b_cnt);
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.a_lk = ma.lk; e.a_p = ma.pulse; e.a_cnt = ma.errs;
        e.b_lk = mb.lk; e.b_p = mb.pulse; e.b_cnt = mb.errs;
        return e;
    endfunction

    // Monitor: outputs are present every cycle; compare against the oldest prediction
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            chk_all(sb.pop_front());
        end
    end

    task automatic cycle(input bit v, input bit [15:0] d, input bit clr);
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        #1;
        ma = step(ma, v, d, clr, 4, 3, 65535);
        mb = step(mb, v, d, clr, 4, 8, 3);
        sb.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic run(input bit [15:0] seed, input int n, input int max_gap);
        bit [15:0] x;
        x = seed;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            cycle(1'b1, x, 1'b0);
            x = nxt(x);
        end
    endtask

    task automatic async_reset();
        exp_t e;
        #2;
        nReset = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        e = snapshot();
        chk_all(e);
        @(negedge clk);
        nReset = 1'b1;
    endtask

    task automatic wrong_word();
        bit [15:0] d;
        d = ma.exp ^ 16'($urandom_range(1, 65535));
        if (d == mb.exp) d = d ^ 16'h8001;
        if (d == ma.exp) d = d ^ 16'h0002;
        cycle(1'b1, d, 1'b0);
    endtask

    initial begin
        exp_t e;
        nReset   = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        clear    = 1'b0;
        ma = mdl_reset();
        mb = mdl_reset();

        // reset before any clock edge
        #10;
        e = snapshot();
        chk_all(e);
        @(negedge clk);
        nReset = 1'b1;
        idle(10);

        // acquire with the reference sequence, then one corrupt word
        cycle(1'b1, 16'hACE1, 1'b0);
        cycle(1'b1, 16'h59C3, 1'b0);
        cycle(1'b1, 16'hB387, 1'b0);
        cycle(1'b1, 16'h670F, 1'b0);
        cycle(1'b1, 16'hCE1E, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0);
        cycle(1'b1, 16'h3879, 1'b0);
        cycle(1'b1, nxt(16'h3879), 1'b0);
        idle(2);

        // loss of lock and reacquisition on a fresh run
        cycle(1'b1, ma.exp, 1'b0);
        wrong_word();
        wrong_word();
        wrong_word();
        run(16'($urandom_range(1, 65535)), 5, 0);
        run(ma.exp, 3, 0);

        // reset mid-lock, zero words in search, gapped acquisition
        async_reset();
        cycle(1'b1, 16'h0000, 1'b0);
        cycle(1'b1, 16'h0000, 1'b0);
        run(16'hACE1, 5, 3);
        run(ma.exp, 3, 3);

        // saturation on the 2-bit counter, then clear against a mismatch
        for (int i = 0; i < 5; i++) wrong_word();
        in_valid = 1'b1;
        in_data  = ma.exp ^ 16'h0F0F;
        if (in_data == mb.exp) in_data = in_data ^ 16'h0001;
        cycle(1'b1, in_data, 1'b1);
        idle(2);

        // randomized traffic
        async_reset();
        for (int i = 0; i < 600; i++) begin
            bit        v;
            bit [15:0] d;
            int        r;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 75 && ma.exp != 0) d = ma.exp;
            else if (r < 80) d = 16'h0000;
            else if (r < 85 && mb.exp != 0) d = mb.exp;
            else d = 16'($urandom);
            cycle(v, d, ($urandom_range(0, 40) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
